// File: rtl/mxm_seq_ctrl.sv
// rtl/mxm_seq_ctrl.sv - streamed (MxN)x(NxP) multiply sequencer and accumulator
// Walks i, j, k (k innermost), accumulates A*X over k and emits one Y per N operands.
module mxm_seq_ctrl #(
    parameter int W = 8,
    parameter int M = 4,
    parameter int N = 8,
    parameter int P = 4,
    localparam int IW = (M > 1) ? $clog2(M) : 1,
    localparam int KW = (N > 1) ? $clog2(N) : 1,
    localparam int JW = (P > 1) ? $clog2(P) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] idx_i,
    output logic [KW-1:0] idx_k,
    output logic [JW-1:0] idx_j,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [W-1:0]  a_in,
    input  logic [W-1:0]  x_in,
    output logic          y_valid,
    input  logic          y_ready,
    output logic [W-1:0]  y_data,
    output logic [IW-1:0] y_i,
    output logic [JW-1:0] y_j
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [IW-1:0] I_LAST = IW'(M - 1);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [JW-1:0] J_LAST = JW'(P - 1);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] i_q, i_d, yi_q, yi_d;
    logic [KW-1:0] k_q, k_d;
    logic [JW-1:0] j_q, j_d, yj_q, yj_d;
    logic [W-1:0]  acc_q, acc_d, y_data_q, y_data_d;
    logic          y_valid_q, y_valid_d, done_q, done_d;

    logic [W-1:0] prod, sum;
    logic         fire;

    // Product and sum both wrap mod 2^W by construction of their widths.
    assign prod = a_in * x_in;
    assign sum  = acc_q + prod;

    // The single output register can be refilled on the same edge it drains.
    assign op_ready = (state_q == S_RUN) && (!y_valid_q || y_ready);
    assign fire     = op_valid && op_ready;

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign idx_i   = i_q;
    assign idx_k   = k_q;
    assign idx_j   = j_q;
    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign y_i     = yi_q;
    assign y_j     = yj_q;

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        k_d       = k_q;
        j_d       = j_q;
        acc_d     = acc_q;
        y_data_d  = y_data_q;
        yi_d      = yi_q;
        yj_d      = yj_q;
        y_valid_d = y_valid_q;
        done_d    = 1'b0;
        if (y_valid_q && y_ready) begin
            y_valid_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    i_d     = '0;
                    k_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                end
            end
            S_RUN: begin
                if (fire) begin
                    if (k_q != K_LAST) begin
                        acc_d = sum;
                        k_d   = k_q + 1'b1;
                    end else begin
                        y_data_d  = sum;
                        yi_d      = i_q;
                        yj_d      = j_q;
                        y_valid_d = 1'b1;
                        acc_d     = '0;
                        k_d       = '0;
                        if (j_q != J_LAST) begin
                            j_d = j_q + 1'b1;
                        end else begin
                            j_d = '0;
                            if (i_q != I_LAST) begin
                                i_d = i_q + 1'b1;
                            end else begin
                                i_d     = '0;
                                state_d = S_FLUSH;
                            end
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (y_valid_q && y_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            k_q       <= '0;
            j_q       <= '0;
            acc_q     <= '0;
            y_data_q  <= '0;
            yi_q      <= '0;
            yj_q      <= '0;
            y_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            k_q       <= k_d;
            j_q       <= j_d;
            acc_q     <= acc_d;
            y_data_q  <= y_data_d;
            yi_q      <= yi_d;
            yj_q      <= yj_d;
            y_valid_q <= y_valid_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_mxm_seq_ctrl.sv
// tb/tb_mxm_seq_ctrl.sv - scoreboard bench for mxm_seq_ctrl
// Three instances: 2x3x2 (main), 1x2x1 (truncation), 1x1x1 (degenerate).
module tb_mxm_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start    [3];
    logic       op_valid [3];
    logic       y_ready  [3];
    logic [7:0] a_in     [3];
    logic [7:0] x_in     [3];
    logic       busy     [3];
    logic       done     [3];
    logic       op_ready [3];
    logic       y_valid  [3];
    logic [7:0] y_data   [3];
    logic       ii       [3];
    logic [1:0] kk       [3];
    logic       jj       [3];
    logic       yi       [3];
    logic       yj       [3];
    logic       k1n, k2n;

    typedef struct {
        int d;
        int v;
        int i;
        int j;
    } exp_t;
    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt [3];
    int done_cyc [3];
    logic       held_v [3];
    logic [7:0] held_d [3];

    int A1 [2][3] = '{'{1, 2, 3}, '{4, 5, 6}};
    int X1 [3][2] = '{'{1, 0}, '{0, 1}, '{1, 1}};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign kk[1] = {1'b0, k1n};
    assign kk[2] = {1'b0, k2n};

    mxm_seq_ctrl #(.W(8), .M(2), .N(3), .P(2)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .idx_i(ii[0]), .idx_k(kk[0]), .idx_j(jj[0]), .op_valid(op_valid[0]),
        .op_ready(op_ready[0]), .a_in(a_in[0]), .x_in(x_in[0]), .y_valid(y_valid[0]),
        .y_ready(y_ready[0]), .y_data(y_data[0]), .y_i(yi[0]), .y_j(yj[0])
    );

    mxm_seq_ctrl #(.W(8), .M(1), .N(2), .P(1)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .idx_i(ii[1]), .idx_k(k1n), .idx_j(jj[1]), .op_valid(op_valid[1]),
        .op_ready(op_ready[1]), .a_in(a_in[1]), .x_in(x_in[1]), .y_valid(y_valid[1]),
        .y_ready(y_ready[1]), .y_data(y_data[1]), .y_i(yi[1]), .y_j(yj[1])
    );

    mxm_seq_ctrl #(.W(8), .M(1), .N(1), .P(1)) dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .idx_i(ii[2]), .idx_k(k2n), .idx_j(jj[2]), .op_valid(op_valid[2]),
        .op_ready(op_ready[2]), .a_in(a_in[2]), .x_in(x_in[2]), .y_valid(y_valid[2]),
        .y_ready(y_ready[2]), .y_data(y_data[2]), .y_i(yi[2]), .y_j(yj[2])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int d, input int v, input int i, input int j);
        exp_t e;
        e.d = d; e.v = v; e.i = i; e.j = j;
        exp_q.push_back(e);
    endtask

    // Monitor: sampled after all negedge-driven inputs have settled.
    always @(negedge clk) begin
        exp_t e;
        #2;
        for (int d = 0; d < 3; d++) begin
            if (held_v[d]) begin
                chk("y_hold_valid", int'(y_valid[d]), 1);
                chk("y_hold_data", int'(y_data[d]), int'(held_d[d]));
            end
            held_v[d] = y_valid[d] && !y_ready[d];
            held_d[d] = y_data[d];
            if (done[d]) begin
                done_cnt[d]++;
                done_cyc[d] = cyc;
            end
            if (y_valid[d] && y_ready[d]) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL y_unexpected: dut%0d gave y=%0d with no expected entry", d, y_data[d]);
                end else begin
                    e = exp_q.pop_front();
                    chk("y_inst", d, e.d);
                    chk("y_data", int'(y_data[d]), e.v);
                    chk("y_i", int'(yi[d]), e.i);
                    chk("y_j", int'(yj[d]), e.j);
                end
            end
        end
    end

    // All stimulus tasks are entered and left on a falling edge.
    task automatic start_run(input int d);
        start[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[d] = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic feed(input int d, input int a, input int x, input int ei, input int ek, input int ej);
        int t = 0;
        op_valid[d] = 1'b1;
        a_in[d] = 8'(a);
        x_in[d] = 8'(x);
        #1;
        while (!op_ready[d] && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("op_ready_wait", int'(op_ready[d]), 1);
        chk("idx_i", int'(ii[d]), ei);
        chk("idx_k", int'(kk[d]), ek);
        chk("idx_j", int'(jj[d]), ej);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done(input int d, input int prev);
        int t = 0;
        while (done_cnt[d] == prev && t < 200) begin
            @(negedge clk);
            #3;
            t++;
        end
        chk("done_count", done_cnt[d] - prev, 1);
        @(negedge clk);
    endtask

    task automatic run_mat();
        int prev = done_cnt[0];
        start_run(0);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                for (int k = 0; k < 3; k++)
                    feed(0, A1[i][k], X1[k][j], i, k, j);
        op_valid[0] = 1'b0;
        wait_done(0, prev);
    endtask

    task automatic push_t1();
        push(0, 4, 0, 0);
        push(0, 5, 0, 1);
        push(0, 10, 1, 0);
        push(0, 11, 1, 1);
    endtask

    initial begin
        int prev;
        int g;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start[d] = 1'b0; op_valid[d] = 1'b0; y_ready[d] = 1'b1;
            a_in[d] = 8'd0; x_in[d] = 8'd0;
            done_cnt[d] = 0; done_cyc[d] = 0; held_v[d] = 1'b0; held_d[d] = 8'd0;
        end
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_op_ready", int'(op_ready[0]), 0);
        chk("rst_y_valid", int'(y_valid[0]), 0);
        chk("rst_done", int'(done[0]), 0);
        chk("rst_y_data", int'(y_data[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // T1: continuous stream, consumer always ready
        push_t1();
        run_mat();
        chk("t1_done_latency", done_cyc[0] - start_cyc, 13);
        chk("t1_busy_after", int'(busy[0]), 0);
        chk("t1_queue_empty", exp_q.size(), 0);

        // T2: consumer stalls 5 cycles at the first Y
        push_t1();
        fork
            run_mat();
            begin
                int t = 0;
                while (!y_valid[0] && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                y_ready[0] = 1'b0;
                repeat (5) begin
                    #1;
                    chk("t2_op_ready_blocked", int'(op_ready[0]), 0);
                    chk("t2_y_held", int'(y_data[0]), 4);
                    @(negedge clk);
                end
                y_ready[0] = 1'b1;
            end
        join
        chk("t2_queue_empty", exp_q.size(), 0);

        // T3: truncation of each product to 8 bits
        push(1, 0, 0, 0);
        prev = done_cnt[1];
        start_run(1);
        feed(1, 16, 16, 0, 0, 0);
        feed(1, 16, 16, 0, 1, 0);
        op_valid[1] = 1'b0;
        wait_done(1, prev);
        push(1, 1, 0, 0);
        prev = done_cnt[1];
        start_run(1);
        feed(1, 255, 255, 0, 0, 0);
        feed(1, 0, 0, 0, 1, 0);
        op_valid[1] = 1'b0;
        wait_done(1, prev);
        chk("t3_queue_empty", exp_q.size(), 0);

        // T4: start pulsed mid-run is ignored
        push_t1();
        prev = done_cnt[0];
        fork
            run_mat();
            begin
                repeat (5) @(negedge clk);
                start[0] = 1'b1;
                @(negedge clk);
                start[0] = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        chk("t4_single_done", done_cnt[0] - prev, 1);
        chk("t4_idle_after", int'(busy[0]), 0);
        chk("t4_queue_empty", exp_q.size(), 0);

        // T5: reset after 4 fires aborts, then a clean rerun
        push(0, 4, 0, 0);
        start_run(0);
        feed(0, 1, 1, 0, 0, 0);
        feed(0, 2, 0, 0, 1, 0);
        feed(0, 3, 1, 0, 2, 0);
        feed(0, 1, 0, 0, 0, 1);
        op_valid[0] = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", int'(busy[0]), 0);
        chk("t5_rst_op_ready", int'(op_ready[0]), 0);
        chk("t5_rst_y_valid", int'(y_valid[0]), 0);
        chk("t5_rst_y_data", int'(y_data[0]), 0);
        chk("t5_rst_idx_k", int'(kk[0]), 0);
        chk("t5_rst_idx_j", int'(jj[0]), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("t5_partial_popped", exp_q.size(), 0);
        @(negedge clk);
        push_t1();
        run_mat();
        chk("t5_queue_empty", exp_q.size(), 0);

        // T6: 1x1x1, then repeated with idle gaps before the operand
        push(2, 63, 0, 0);
        prev = done_cnt[2];
        start_run(2);
        feed(2, 7, 9, 0, 0, 0);
        op_valid[2] = 1'b0;
        #1;
        chk("t6_flush_busy", int'(busy[2]), 1);
        chk("t6_flush_op_ready", int'(op_ready[2]), 0);
        chk("t6_y_valid", int'(y_valid[2]), 1);
        chk("t6_y_data", int'(y_data[2]), 63);
        wait_done(2, prev);
        chk("t6_done_latency", done_cyc[2] - start_cyc, 2);
        for (int r = 0; r < 3; r++) begin
            push(2, 63, 0, 0);
            prev = done_cnt[2];
            start_run(2);
            g = $urandom_range(1, 4);
            repeat (g) @(negedge clk);
            feed(2, 7, 9, 0, 0, 0);
            op_valid[2] = 1'b0;
            wait_done(2, prev);
        end
        chk("t6_queue_empty", exp_q.size(), 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
